// File: rtl/ct_vfalu_wb_pipen_pkg.sv
// Shared defaults for the VFALU writeback stage: widths, legal result latency and unit indices.
// Optional check logic is enabled by defining CT_VFALU_WB_CHK_EN.
package ct_vfalu_wb_pipen_pkg;

  localparam int unsigned DEF_DATA_W   = 64;
  localparam int unsigned DEF_NUM_UNIT = 3;
  localparam int unsigned DEF_EREG_W   = 5;
  localparam int unsigned DEF_PREG_W   = 7;
  localparam int unsigned DEF_RES_LAT  = 3;

  // Result latency is counted with ex1 as stage 1.
  localparam int unsigned RES_LAT_MIN  = 2;
  localparam int unsigned RES_LAT_MAX  = 6;

  typedef enum logic [1:0] {
    UNIT_FADD  = 2'd0,
    UNIT_FSPU  = 2'd1,
    UNIT_FCNVT = 2'd2
  } unit_idx_e;

endpackage

// File: rtl/ct_vfalu_wb_pipen_if.sv
// Unit/dispatch-facing bus of the VFALU writeback stage; wb_err exists only with CT_VFALU_WB_CHK_EN.
interface ct_vfalu_wb_pipen_if
  import ct_vfalu_wb_pipen_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_UNIT = DEF_NUM_UNIT,
  parameter int unsigned EREG_W   = DEF_EREG_W,
  parameter int unsigned PREG_W   = DEF_PREG_W
);

  logic                         ex1_inst_vld;
  logic [NUM_UNIT-1:0]          ex1_sel;
  logic [PREG_W-1:0]            ex1_preg;
  logic                         flush;
  logic [NUM_UNIT*DATA_W-1:0]   unit_mfvr_data;
  logic [NUM_UNIT-1:0]          unit_fwd_vld;
  logic [NUM_UNIT*DATA_W-1:0]   unit_fwd_result;
  logic [NUM_UNIT-1:0]          unit_ereg_vld;
  logic [NUM_UNIT*EREG_W-1:0]   unit_ereg;
  logic                         fflags_clr;
  logic [DATA_W-1:0]            ex1_mfvr_data;
  logic                         wb_vld;
  logic [PREG_W-1:0]            wb_preg;
  logic [DATA_W-1:0]            wb_freg_data;
  logic [EREG_W-1:0]            wb_ereg_data;
  logic [EREG_W-1:0]            fflags_sticky;
`ifdef CT_VFALU_WB_CHK_EN
  logic                         wb_err;
`endif

  // Driver side: dispatch logic and unit tops.
  modport master (
    output ex1_inst_vld, ex1_sel, ex1_preg, flush, unit_mfvr_data,
           unit_fwd_vld, unit_fwd_result, unit_ereg_vld, unit_ereg, fflags_clr,
    input  ex1_mfvr_data, wb_vld, wb_preg, wb_freg_data, wb_ereg_data, fflags_sticky
`ifdef CT_VFALU_WB_CHK_EN
    , input wb_err
`endif
  );

  // Writeback stage side.
  modport slave (
    input  ex1_inst_vld, ex1_sel, ex1_preg, flush, unit_mfvr_data,
           unit_fwd_vld, unit_fwd_result, unit_ereg_vld, unit_ereg, fflags_clr,
    output ex1_mfvr_data, wb_vld, wb_preg, wb_freg_data, wb_ereg_data, fflags_sticky
`ifdef CT_VFALU_WB_CHK_EN
    , output wb_err
`endif
  );

endinterface

// File: rtl/ct_vfalu_res_mux.sv
// Parametrised AND-OR mux: ORs together every packed data slice whose select bit is set.
module ct_vfalu_res_mux
  import ct_vfalu_wb_pipen_pkg::*;
#(
  parameter int unsigned NUM_UNIT = DEF_NUM_UNIT,
  parameter int unsigned W        = DEF_DATA_W
) (
  input  logic [NUM_UNIT-1:0]   i_sel,
  input  logic [NUM_UNIT*W-1:0] i_data,
  output logic [W-1:0]          o_data_c
);

  always_comb begin
    o_data_c = '0;
    for (int unsigned i = 0; i < NUM_UNIT; i++) begin
      o_data_c = o_data_c | (i_data[i*W +: W] & {W{i_sel[i]}});
    end
  end

endmodule

// File: rtl/ct_vfalu_wb_pipen.sv
// VFALU result collection / writeback: RES_LAT-deep tag tracker, result capture, sticky fflags, ex1 mfvr mux.
// Define CT_VFALU_WB_CHK_EN to add the sticky wb_err protocol checker.
module ct_vfalu_wb_pipen
  import ct_vfalu_wb_pipen_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_UNIT = DEF_NUM_UNIT,
  parameter int unsigned EREG_W   = DEF_EREG_W,
  parameter int unsigned PREG_W   = DEF_PREG_W,
  parameter int unsigned RES_LAT  = DEF_RES_LAT   // legal RES_LAT_MIN..RES_LAT_MAX
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  ct_vfalu_wb_pipen_if.slave   bus
);

  // Tracker stages ex2..exRES_LAT live at indices 0..NSTG-1.
  localparam int unsigned NSTG = RES_LAT - 1;
  localparam int unsigned LAST = NSTG - 1;

  logic [NSTG-1:0]     r_vld;
  logic [NUM_UNIT-1:0] r_sel  [NSTG];
  logic [PREG_W-1:0]   r_preg [NSTG];

  logic                r_wb_vld;
  logic [PREG_W-1:0]   r_wb_preg;
  logic [DATA_W-1:0]   r_wb_data;
  logic [EREG_W-1:0]   r_wb_ereg;
  logic [EREG_W-1:0]   r_fflags;

  logic                w_capture;
  logic [NUM_UNIT-1:0] w_last_sel;
  logic [NUM_UNIT-1:0] w_res_sel;
  logic [NUM_UNIT-1:0] w_ereg_sel;
  logic [DATA_W-1:0]   w_res_data;
  logic [EREG_W-1:0]   w_res_ereg;

  // Valid/tag pipeline; flush kills the incoming issue and every in-flight entry.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_vld <= '0;
      for (int unsigned k = 0; k < NSTG; k++) begin
        r_sel[k]  <= '0;
        r_preg[k] <= '0;
      end
    end else begin
      r_vld[0]  <= bus.ex1_inst_vld & ~bus.flush;
      r_sel[0]  <= bus.ex1_sel;
      r_preg[0] <= bus.ex1_preg;
      for (int unsigned k = 1; k < NSTG; k++) begin
        r_vld[k]  <= r_vld[k-1] & ~bus.flush;
        r_sel[k]  <= r_sel[k-1];
        r_preg[k] <= r_preg[k-1];
      end
    end
  end

  assign w_last_sel = r_sel[LAST];
  assign w_capture  = r_vld[LAST] & ~bus.flush;

  // Units without a valid result contribute zero data / zero flags.
  assign w_res_sel  = w_last_sel & bus.unit_fwd_vld;
  assign w_ereg_sel = w_last_sel & bus.unit_ereg_vld;

  ct_vfalu_res_mux #(
    .NUM_UNIT (NUM_UNIT),
    .W        (DATA_W)
  ) u_mfvr_mux (
    .i_sel    (bus.ex1_sel),
    .i_data   (bus.unit_mfvr_data),
    .o_data_c (bus.ex1_mfvr_data)
  );

  ct_vfalu_res_mux #(
    .NUM_UNIT (NUM_UNIT),
    .W        (DATA_W)
  ) u_res_mux (
    .i_sel    (w_res_sel),
    .i_data   (bus.unit_fwd_result),
    .o_data_c (w_res_data)
  );

  ct_vfalu_res_mux #(
    .NUM_UNIT (NUM_UNIT),
    .W        (EREG_W)
  ) u_ereg_mux (
    .i_sel    (w_ereg_sel),
    .i_data   (bus.unit_ereg),
    .o_data_c (w_res_ereg)
  );

  // Writeback registers hold their payload across non-capture cycles.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_wb_vld  <= 1'b0;
      r_wb_preg <= '0;
      r_wb_data <= '0;
      r_wb_ereg <= '0;
      r_fflags  <= '0;
    end else begin
      r_wb_vld <= w_capture;
      if (w_capture) begin
        r_wb_preg <= r_preg[LAST];
        r_wb_data <= w_res_data;
        r_wb_ereg <= w_res_ereg;
      end
      // Clear applies to the old value only, so flags captured in the same cycle survive.
      r_fflags <= (bus.fflags_clr ? '0 : r_fflags) | (w_capture ? w_res_ereg : '0);
    end
  end

  assign bus.wb_vld        = r_wb_vld;
  assign bus.wb_preg       = r_wb_preg;
  assign bus.wb_freg_data  = r_wb_data;
  assign bus.wb_ereg_data  = r_wb_ereg;
  assign bus.fflags_sticky = r_fflags;

`ifdef CT_VFALU_WB_CHK_EN
  logic                r_wb_err;
  logic                w_sel_bad;
  logic                w_vld_miss;
  logic                w_vld_orphan;
  logic [NUM_UNIT-1:0] w_cap_sel;

  assign w_cap_sel    = {NUM_UNIT{w_capture}} & w_last_sel;
  assign w_sel_bad    = w_capture &
                        ((w_last_sel == '0) || ((w_last_sel & (w_last_sel - NUM_UNIT'(1))) != '0));
  assign w_vld_miss   = w_capture & ((w_last_sel & ~bus.unit_fwd_vld) != '0);
  assign w_vld_orphan = (bus.unit_fwd_vld & ~w_cap_sel) != '0;

  // Sticky until reset.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_wb_err <= 1'b0;
    end else begin
      r_wb_err <= r_wb_err | w_sel_bad | w_vld_miss | w_vld_orphan;
    end
  end

  assign bus.wb_err = r_wb_err;
`endif

endmodule
